// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - I-side/D-side cacheline arbiter for the shared physical memory port
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   imem_read/imem_address        I-side line read request (level) and line address
//   imem_rdata/imem_resp          I-side read data and one-cycle completion pulse
//   dmem_read/dmem_write          D-side line read / writeback request (level)
//   dmem_address/dmem_wdata       D-side line address and writeback data
//   dmem_rdata/dmem_resp          D-side read data and one-cycle completion pulse
//   pmem_read/pmem_write          physical memory request, registered
//   pmem_address/pmem_wdata       physical address and write data, registered
//   pmem_rdata/pmem_resp          physical read data and one-cycle completion
module cacheline_arbiter #(
    parameter int LINE_W       = 256,
    parameter int ADDR_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_read,
    input  logic [ADDR_W-1:0] imem_address,
    output logic [LINE_W-1:0] imem_rdata,
    output logic              imem_resp,
    input  logic              dmem_read,
    input  logic              dmem_write,
    input  logic [ADDR_W-1:0] dmem_address,
    input  logic [LINE_W-1:0] dmem_wdata,
    output logic [LINE_W-1:0] dmem_rdata,
    output logic              dmem_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2
    } state_t;

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_D_STREAK);

    state_t     state;
    logic [3:0] streak;
    logic       d_req;
    logic       grant_i;
    logic       grant_d;

    // D wins contention unless it has already been granted STREAK_LIMIT times
    // in a row while I was waiting.
    always_comb begin
        d_req   = dmem_read | dmem_write;
        grant_i = imem_read & (~d_req | (streak >= STREAK_LIMIT));
        grant_d = d_req & ~grant_i;
    end

    // The pmem_* registers double as the request latches: address, op and
    // write data are captured on grant and held for the whole transaction.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            streak       <= '0;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_i) begin
                        state        <= SERVE_I;
                        pmem_read    <= 1'b1;
                        pmem_write   <= 1'b0;
                        pmem_address <= imem_address;
                        streak       <= '0;
                    end else if (grant_d) begin
                        state        <= SERVE_D;
                        // read+write together is treated as a writeback
                        pmem_read    <= ~dmem_write;
                        pmem_write   <= dmem_write;
                        pmem_address <= dmem_address;
                        pmem_wdata   <= dmem_wdata;
                        if (!imem_read) begin
                            streak <= '0;
                        end else if (streak != 4'hf) begin
                            streak <= streak + 4'd1;
                        end
                    end
                end
                SERVE_I, SERVE_D: begin
                    if (pmem_resp) begin
                        state      <= IDLE;
                        pmem_read  <= 1'b0;
                        pmem_write <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    pmem_read  <= 1'b0;
                    pmem_write <= 1'b0;
                end
            endcase
        end
    end

    // A pmem_resp seen in IDLE (stray or left over from an aborted
    // transaction) produces no response on either side.
    always_comb begin
        imem_resp  = pmem_resp & (state == SERVE_I);
        dmem_resp  = pmem_resp & (state == SERVE_D);
        imem_rdata = imem_resp ? pmem_rdata : '0;
        dmem_rdata = dmem_resp ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - self-checking bench for cacheline_arbiter
module tb_cacheline_arbiter;

    localparam int LINE_W       = 256;
    localparam int ADDR_W       = 32;
    localparam int MAX_D_STREAK = 4;

    localparam int NONE   = 0;
    localparam int SIDE_I = 1;
    localparam int SIDE_D = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              imem_read;
    logic [ADDR_W-1:0] imem_address;
    logic [LINE_W-1:0] imem_rdata;
    logic              imem_resp;
    logic              dmem_read;
    logic              dmem_write;
    logic [ADDR_W-1:0] dmem_address;
    logic [LINE_W-1:0] dmem_wdata;
    logic [LINE_W-1:0] dmem_rdata;
    logic              dmem_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    cacheline_arbiter #(
        .LINE_W      (LINE_W),
        .ADDR_W      (ADDR_W),
        .MAX_D_STREAK(MAX_D_STREAK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_read   (imem_read),
        .imem_address(imem_address),
        .imem_rdata  (imem_rdata),
        .imem_resp   (imem_resp),
        .dmem_read   (dmem_read),
        .dmem_write  (dmem_write),
        .dmem_address(dmem_address),
        .dmem_wdata  (dmem_wdata),
        .dmem_rdata  (dmem_rdata),
        .dmem_resp   (dmem_resp),
        .pmem_read   (pmem_read),
        .pmem_write  (pmem_write),
        .pmem_address(pmem_address),
        .pmem_wdata  (pmem_wdata),
        .pmem_rdata  (pmem_rdata),
        .pmem_resp   (pmem_resp)
    );

    always #5 clk = ~clk;

    // Transaction-level reference: who currently owns memory and what it asked for.
    int                m_side = NONE;
    logic              m_wr = 1'b0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    int                m_streak = 0;
    bit                m_en = 1'b0;

    int   n_vec = 0;
    int   n_bad = 0;
    logic i_resp_seen = 1'b0;
    logic d_resp_seen = 1'b0;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [LINE_W-1:0] rand_line();
        logic [LINE_W-1:0] v;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Called at a negedge with inputs already applied: compare, then advance
    // the reference on the posedge, and return at the next negedge.
    task automatic cycle();
        logic d_req;
        #1;
        if (m_en) begin
            chk("pmem_read", pmem_read, m_side == SIDE_I || (m_side == SIDE_D && !m_wr));
            chk("pmem_write", pmem_write, m_side == SIDE_D && m_wr);
            chk("pmem_address", pmem_address, m_addr);
            chk("pmem_wdata", pmem_wdata, m_wdata);
            chk("imem_resp", imem_resp, m_side == SIDE_I && pmem_resp);
            chk("dmem_resp", dmem_resp, m_side == SIDE_D && pmem_resp);
            chk("imem_rdata", imem_rdata, (m_side == SIDE_I && pmem_resp) ? pmem_rdata : '0);
            chk("dmem_rdata", dmem_rdata, (m_side == SIDE_D && pmem_resp) ? pmem_rdata : '0);
        end
        i_resp_seen = imem_resp;
        d_resp_seen = dmem_resp;
        @(posedge clk);
        d_req = dmem_read | dmem_write;
        if (rst) begin
            m_side = NONE; m_wr = 1'b0; m_addr = '0; m_wdata = '0; m_streak = 0; m_en = 1'b1;
        end else if (m_side != NONE) begin
            if (pmem_resp) m_side = NONE;
        end else if (imem_read && (!d_req || m_streak >= MAX_D_STREAK)) begin
            m_side = SIDE_I; m_addr = imem_address; m_streak = 0;
        end else if (d_req) begin
            m_side = SIDE_D; m_wr = dmem_write; m_addr = dmem_address; m_wdata = dmem_wdata;
            m_streak = imem_read ? ((m_streak < 15) ? m_streak + 1 : 15) : 0;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [4:0]        seq;
        int                ng;
        int                i_wait;
        int                max_i_wait;
        logic [LINE_W-1:0] a5_line;
        logic [LINE_W-1:0] w_line;

        a5_line = {32{8'hA5}};
        w_line  = {8{32'h1234_5678}};
        rst = 1'b1; imem_read = 1'b0; imem_address = '0;
        dmem_read = 1'b0; dmem_write = 1'b0; dmem_address = '0; dmem_wdata = '0;
        pmem_rdata = '0; pmem_resp = 1'b0;
        @(negedge clk);
        cycle();
        chk("rst_pmem_read", pmem_read, 0);
        chk("rst_pmem_write", pmem_write, 0);
        chk("rst_pmem_address", pmem_address, 0);
        chk("rst_pmem_wdata", pmem_wdata, 0);
        chk("rst_resp", {imem_resp, dmem_resp}, 0);
        rst = 1'b0;
        cycle();

        // I only, memory answers after 3 wait cycles
        imem_read = 1'b1; imem_address = 32'h0000_0040;
        cycle();
        chk("i_only_rise", {pmem_read, pmem_write}, 2'b10);
        chk("i_only_addr", pmem_address, 32'h0000_0040);
        repeat (3) cycle();
        pmem_resp = 1'b1; pmem_rdata = a5_line;
        #1;
        chk("i_only_resp", {imem_resp, dmem_resp}, 2'b10);
        chk("i_only_rdata", imem_rdata, a5_line);
        cycle();
        imem_read = 1'b0; pmem_resp = 1'b0;
        #1;
        chk("i_only_pulse", imem_resp, 0);
        cycle();

        // D writeback
        dmem_write = 1'b1; dmem_address = 32'h0000_1000; dmem_wdata = w_line;
        cycle();
        chk("d_wr_op", {pmem_read, pmem_write}, 2'b01);
        chk("d_wr_addr", pmem_address, 32'h0000_1000);
        chk("d_wr_data", pmem_wdata, w_line);
        cycle();
        pmem_resp = 1'b1;
        #1;
        chk("d_wr_resp", {imem_resp, dmem_resp}, 2'b01);
        cycle();
        dmem_write = 1'b0; pmem_resp = 1'b0;
        cycle();

        // Contention from IDLE with streak 0: D first, then I
        imem_read = 1'b1; imem_address = 32'h0000_0080;
        dmem_read = 1'b1; dmem_address = 32'h0000_2000;
        cycle();
        chk("cont_first_d", pmem_address, 32'h0000_2000);
        pmem_resp = 1'b1;
        #1;
        chk("cont_d_resp", {imem_resp, dmem_resp}, 2'b01);
        cycle();
        dmem_read = 1'b0; pmem_resp = 1'b0;
        cycle();
        chk("cont_then_i", {pmem_read, pmem_address}, {1'b1, 32'h0000_0080});
        pmem_resp = 1'b1;
        #1;
        chk("cont_i_resp", {imem_resp, dmem_resp}, 2'b10);
        cycle();
        imem_read = 1'b0; pmem_resp = 1'b0;
        cycle();

        // Starvation: D re-requests continuously while I waits
        imem_read = 1'b1; imem_address = 32'h0000_0100;
        dmem_read = 1'b1; dmem_address = 32'h0000_3000;
        seq = '0; ng = 0;
        for (int k = 0; k < 60 && ng < 5; k++) begin
            pmem_resp = pmem_read | pmem_write;
            pmem_rdata = rand_line();
            #1;
            if (imem_resp) begin seq[ng] = 1'b1; ng++; end
            else if (dmem_resp) begin seq[ng] = 1'b0; ng++; end
            cycle();
        end
        chk("starve_count", ng, 5);
        chk("starve_order", seq, 5'b10000);
        imem_read = 1'b0; dmem_read = 1'b0; pmem_resp = 1'b0;
        cycle();

        // Reset in the middle of a writeback, late pmem_resp
        dmem_write = 1'b1; dmem_address = 32'h0000_4000; dmem_wdata = rand_line();
        cycle();
        chk("rmid_write", pmem_write, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0; dmem_write = 1'b0;
        chk("rmid_abort", {pmem_read, pmem_write}, 2'b00);
        cycle();
        pmem_resp = 1'b1;
        #1;
        chk("rmid_no_resp", {imem_resp, dmem_resp}, 2'b00);
        cycle();
        pmem_resp = 1'b0;

        // Stray response in IDLE
        pmem_resp = 1'b1;
        #1;
        chk("stray_no_resp", {imem_resp, dmem_resp}, 2'b00);
        cycle();
        pmem_resp = 1'b0;
        chk("stray_idle", {pmem_read, pmem_write}, 2'b00);
        cycle();

        // Randomised traffic against the reference
        i_wait = 0; max_i_wait = 0;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if (i_resp_seen || !imem_read) i_wait = 0;
            else i_wait++;
            if (i_wait > max_i_wait) max_i_wait = i_wait;

            if (i_resp_seen) begin
                imem_read = 1'b0;
            end else if (!imem_read && $urandom_range(0, 2) == 0) begin
                imem_read = 1'b1; imem_address = $urandom;
            end else if (imem_read && m_side == SIDE_I && $urandom_range(0, 1) == 0) begin
                imem_address = $urandom;
            end

            if (d_resp_seen && $urandom_range(0, 1) == 0) begin
                dmem_read = 1'b0; dmem_write = 1'b0;
            end else if ((d_resp_seen || !(dmem_read | dmem_write)) && $urandom_range(0, 1) == 0) begin
                case ($urandom_range(0, 2))
                    0:       begin dmem_read = 1'b1; dmem_write = 1'b0; end
                    1:       begin dmem_read = 1'b0; dmem_write = 1'b1; end
                    default: begin dmem_read = 1'b1; dmem_write = 1'b1; end
                endcase
                dmem_address = $urandom; dmem_wdata = rand_line();
            end else if ((dmem_read | dmem_write) && m_side == SIDE_D && $urandom_range(0, 1) == 0) begin
                dmem_address = $urandom; dmem_wdata = rand_line(); dmem_read = ~dmem_read;
                if (!dmem_read) dmem_write = 1'b1;
            end

            pmem_rdata = rand_line();
            pmem_resp = (pmem_read | pmem_write) ? ($urandom_range(0, 2) == 0)
                                                 : ($urandom_range(0, 9) == 0);
            cycle();
        end
        chk("i_progress", max_i_wait < 200, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
